// File: rtl/lights_out_solver.sv
// lights_out_solver: automatic player for the 3x3 lights-out game.
// Takes a snapshot of the board and searches all 512 press sets for the one
// whose combined toggle pattern equals the snapshot. It then issues that set
// as single-cycle one-hot presses, lets the board settle and confirms that it
// reads all-off.
// Optional build macro LO_SOLVER_STEP_EN adds a 'step' input. Each press then
// waits for a sampled step pulse.
module lights_out_solver #(
  parameter int GAP_CYCLES    = 1,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
`ifdef LO_SOLVER_STEP_EN
  input  logic       step,
`endif
  input  logic [8:0] field_in,
  output logic [8:0] buttons_out,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [3:0] presses
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SEARCH = 3'd1;
  localparam logic [2:0] ST_PRESS  = 3'd2;
  localparam logic [2:0] ST_GAP    = 3'd3;
  localparam logic [2:0] ST_SETTLE = 3'd4;
  localparam logic [2:0] ST_CHECK  = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;
  localparam logic [2:0] ST_FAIL   = 3'd7;

  // Terminal counts of the wait counters. Both parameters are at least 1.
  localparam logic [15:0] GAP_LAST    = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  logic [2:0]  state_r;
  logic [8:0]  snapshot_r;
  logic [8:0]  counter_r;
  logic [8:0]  solution_r;
  logic [15:0] wait_cnt_r;

  logic [8:0]  candidate_s;
  logic        match_s;
  logic [8:0]  press_onehot_s;
  logic        press_ok_s;

  // Cells toggled by pressing one button: the cell itself plus its
  // orthogonal neighbours. The grid does not wrap.
  function automatic logic [8:0] cell_mask(input logic [3:0] idx);
    logic [8:0] m;
    case (idx)
      4'd0:    m = 9'h00B;  // {0,1,3}
      4'd1:    m = 9'h017;  // {0,1,2,4}
      4'd2:    m = 9'h026;  // {1,2,5}
      4'd3:    m = 9'h059;  // {0,3,4,6}
      4'd4:    m = 9'h0BA;  // {1,3,4,5,7}
      4'd5:    m = 9'h134;  // {2,4,5,8}
      4'd6:    m = 9'h0C8;  // {3,6,7}
      4'd7:    m = 9'h1D0;  // {4,6,7,8}
      4'd8:    m = 9'h1A0;  // {5,7,8}
      default: m = 9'h000;
    endcase
    return m;
  endfunction

  // Combined board change for a whole press set: XOR of the per-button masks.
  function automatic logic [8:0] toggle_of(input logic [8:0] x);
    logic [8:0] r;
    r = 9'h000;
    for (int i = 0; i < 9; i++) begin
      if (x[i]) begin
        r = r ^ cell_mask(4'(i));
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Search datapath: tests one candidate press set against the snapshot each
  // cycle. Also isolates the lowest pending press of the solution.
  always_comb begin
    candidate_s    = toggle_of(counter_r);
    match_s        = (candidate_s == snapshot_r);
    press_onehot_s = solution_r & (~solution_r + 9'd1);
  end

`ifdef LO_SOLVER_STEP_EN
  logic step_q_r;

  // Remembers a step pulse that was sampled while pressing. Steps seen in any
  // other state are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q_r <= 1'b0;
    end else if (state_r == ST_PRESS) begin
      step_q_r <= step;
    end else begin
      step_q_r <= 1'b0;
    end
  end

  // A press may only be issued in the cycle after a step was sampled.
  always_comb begin
    press_ok_s = step_q_r;
  end
`else
  // Without single-stepping the presses run back-to-back.
  always_comb begin
    press_ok_s = 1'b1;
  end
`endif

  // Main controller. It holds all registered outputs, so that buttons_out
  // drops to zero asynchronously on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      snapshot_r  <= 9'h000;
      counter_r   <= 9'h000;
      solution_r  <= 9'h000;
      wait_cnt_r  <= 16'd0;
      buttons_out <= 9'h000;
      busy        <= 1'b0;
      done        <= 1'b0;
      fail        <= 1'b0;
      presses     <= 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          buttons_out <= 9'h000;
          if (start) begin
            snapshot_r <= field_in;
            counter_r  <= 9'h000;
            solution_r <= 9'h000;
            done       <= 1'b0;
            fail       <= 1'b0;
            presses    <= 4'd0;
            busy       <= 1'b1;
            state_r    <= ST_SEARCH;
          end else begin
            state_r    <= ST_IDLE;
          end
        end

        ST_SEARCH: begin
          buttons_out <= 9'h000;
          if (match_s) begin
            solution_r <= counter_r;
            state_r    <= ST_PRESS;
          end else if (counter_r == 9'd511) begin
            fail    <= 1'b1;
            busy    <= 1'b0;
            state_r <= ST_FAIL;
          end else begin
            counter_r <= counter_r + 9'd1;
          end
        end

        ST_PRESS: begin
          if (solution_r == 9'h000) begin
            buttons_out <= 9'h000;
            wait_cnt_r  <= 16'd0;
            state_r     <= ST_SETTLE;
          end else if (press_ok_s) begin
            buttons_out <= press_onehot_s;
            presses     <= presses + 4'd1;
            solution_r  <= solution_r & ~press_onehot_s;
            wait_cnt_r  <= 16'd0;
            state_r     <= ST_GAP;
          end else begin
            buttons_out <= 9'h000;
            state_r     <= ST_PRESS;
          end
        end

        ST_GAP: begin
          buttons_out <= 9'h000;
          if (wait_cnt_r == GAP_LAST) begin
            state_r <= ST_PRESS;
          end else begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
          end
        end

        ST_SETTLE: begin
          buttons_out <= 9'h000;
          if (wait_cnt_r == SETTLE_LAST) begin
            state_r <= ST_CHECK;
          end else begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
          end
        end

        ST_CHECK: begin
          buttons_out <= 9'h000;
          busy        <= 1'b0;
          if (field_in == 9'h000) begin
            done    <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            fail    <= 1'b1;
            state_r <= ST_FAIL;
          end
        end

        ST_DONE: begin
          buttons_out <= 9'h000;
          state_r     <= ST_IDLE;
        end

        ST_FAIL: begin
          buttons_out <= 9'h000;
          state_r     <= ST_IDLE;
        end

        default: begin
          buttons_out <= 9'h000;
          busy        <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
